ycbcr2rgb_container: RTL and testbench

//   Inverse colour converter for one 64-pixel block: Q16.16 Y/Cb/Cr in, 8-bit R/G/B out.

---
 rtl/ycbcr2rgb_container.sv | 157 +++++++++++++++
 tb/tb_ycbcr2rgb_container.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr2rgb_container.sv
`default_nettype none
// ============================================================================
// Module      : ycbcr2rgb_container
// Description : Q16.16 YCbCr to 8-bit RGB for one pixel block, CORE_COUNT px/cycle
// Revision    : 1.0
// ============================================================================
module ycbcr2rgb_container #(
    parameter int fixed_point_length = 32,
    parameter int output_width       = 8,
    parameter int PIXEL_COUNT        = 64,
    parameter int CORE_COUNT         = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [fixed_point_length*PIXEL_COUNT-1:0] y_all,
    input  logic [fixed_point_length*PIXEL_COUNT-1:0] cb_all,
    input  logic [fixed_point_length*PIXEL_COUNT-1:0] cr_all,
    output logic [output_width*PIXEL_COUNT-1:0]       r_all,
    output logic [output_width*PIXEL_COUNT-1:0]       g_all,
    output logic [output_width*PIXEL_COUNT-1:0]       b_all,
    output logic                                   done
);

    localparam int FPL     = fixed_point_length;
    localparam int OW      = output_width;
    localparam int BATCHES = PIXEL_COUNT / CORE_COUNT;
    localparam int BW      = (BATCHES > 1) ? $clog2(BATCHES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic signed [63:0] c_chroma_mid = 64'sd8388608;
    localparam logic signed [63:0] c_k_rcr      = 64'sd91881;
    localparam logic signed [63:0] c_k_gcb      = 64'sd22554;
    localparam logic signed [63:0] c_k_gcr      = 64'sd46802;
    localparam logic signed [63:0] c_k_bcb      = 64'sd116130;
    localparam logic signed [63:0] c_round      = 64'sd32768;
    localparam logic signed [63:0] c_out_max    = 64'((64'sd1 <<< OW) - 64'sd1);

    logic [1:0]                  r_state;
    logic [BW-1:0]               r_batch;
    logic [FPL*PIXEL_COUNT-1:0]  r_y;
    logic [FPL*PIXEL_COUNT-1:0]  r_cb;
    logic [FPL*PIXEL_COUNT-1:0]  r_cr;
    logic [OW*PIXEL_COUNT-1:0]   r_r;
    logic [OW*PIXEL_COUNT-1:0]   r_g;
    logic [OW*PIXEL_COUNT-1:0]   r_b;
    logic                        r_done;

    logic [OW-1:0] w_r_px [CORE_COUNT];
    logic [OW-1:0] w_g_px [CORE_COUNT];
    logic [OW-1:0] w_b_px [CORE_COUNT];

    // Sums are kept at full width so the clamp sees the true sign and magnitude.
    function automatic logic [OW-1:0] round_clamp(input logic signed [63:0] sum);
        logic signed [63:0] v;
        v = (sum + c_round) >>> 16;
        if (v < 64'sd0)
            round_clamp = '0;
        else if (v > c_out_max)
            round_clamp = '1;
        else
            round_clamp = v[OW-1:0];
    endfunction

    generate
        for (genvar c = 0; c < CORE_COUNT; c++) begin : g_core
            int                 w_idx;
            logic [FPL-1:0]     w_y_raw;
            logic [FPL-1:0]     w_cb_raw;
            logic [FPL-1:0]     w_cr_raw;
            logic signed [63:0] w_y;
            logic signed [63:0] w_dcb;
            logic signed [63:0] w_dcr;
            logic signed [63:0] w_p_rcr;
            logic signed [63:0] w_p_gcb;
            logic signed [63:0] w_p_gcr;
            logic signed [63:0] w_p_bcb;

            assign w_idx    = int'(r_batch) * CORE_COUNT + c;
            assign w_y_raw  = r_y [w_idx*FPL +: FPL];
            assign w_cb_raw = r_cb[w_idx*FPL +: FPL];
            assign w_cr_raw = r_cr[w_idx*FPL +: FPL];

            assign w_y   = $signed({{(64-FPL){w_y_raw[FPL-1]}},  w_y_raw});
            assign w_dcb = $signed({{(64-FPL){w_cb_raw[FPL-1]}}, w_cb_raw}) - c_chroma_mid;
            assign w_dcr = $signed({{(64-FPL){w_cr_raw[FPL-1]}}, w_cr_raw}) - c_chroma_mid;

            assign w_p_rcr = (w_dcr * c_k_rcr) >>> 16;
            assign w_p_gcb = (w_dcb * c_k_gcb) >>> 16;
            assign w_p_gcr = (w_dcr * c_k_gcr) >>> 16;
            assign w_p_bcb = (w_dcb * c_k_bcb) >>> 16;

            assign w_r_px[c] = round_clamp(w_y + w_p_rcr);
            assign w_g_px[c] = round_clamp(w_y - w_p_gcb - w_p_gcr);
            assign w_b_px[c] = round_clamp(w_y + w_p_bcb);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_batch <= '0;
            r_y     <= '0;
            r_cb    <= '0;
            r_cr    <= '0;
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_y     <= y_all;
                        r_cb    <= cb_all;
                        r_cr    <= cr_all;
                        r_batch <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    for (int c = 0; c < CORE_COUNT; c++) begin
                        r_r[(int'(r_batch)*CORE_COUNT + c)*OW +: OW] <= w_r_px[c];
                        r_g[(int'(r_batch)*CORE_COUNT + c)*OW +: OW] <= w_g_px[c];
                        r_b[(int'(r_batch)*CORE_COUNT + c)*OW +: OW] <= w_b_px[c];
                    end
                    if (r_batch == BW'(BATCHES - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_batch <= r_batch + 1'b1;
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign r_all = r_r;
    assign g_all = r_g;
    assign b_all = r_b;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ycbcr2rgb_container.sv
`default_nettype none
// ============================================================================
// Module      : tb_ycbcr2rgb_container
// Description : Vector table plus scoreboarded random blocks for ycbcr2rgb_container
// Revision    : 1.0
// ============================================================================
module tb_ycbcr2rgb_container;

    localparam int NPIX = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [NPIX*32-1:0] y_all, cb_all, cr_all;
    logic [NPIX*8-1:0]  r_all, g_all, b_all;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string        name;
        logic [511:0] r;
        logic [511:0] g;
        logic [511:0] b;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] y, cb, cr;
        logic [7:0]  r, g, b;
        bit          hold;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];

    ycbcr2rgb_container dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .y_all  (y_all),
        .cb_all (cb_all),
        .cr_all (cr_all),
        .r_all  (r_all),
        .g_all  (g_all),
        .b_all  (b_all),
        .done   (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] clamp8(input longint s);
        longint v;
        v = (s + 64'sd32768) >>> 16;
        if (v < 0)   return 8'd0;
        if (v > 255) return 8'd255;
        return v[7:0];
    endfunction

    function automatic void model(input logic [31:0] y, input logic [31:0] cb, input logic [31:0] cr,
                                  output logic [7:0] r, output logic [7:0] g, output logic [7:0] b);
        longint yy, dcb, dcr;
        yy  = longint'(signed'(y));
        dcb = longint'(signed'(cb)) - 64'sd8388608;
        dcr = longint'(signed'(cr)) - 64'sd8388608;
        r = clamp8(yy + ((dcr * 64'sd91881) >>> 16));
        g = clamp8(yy - ((dcb * 64'sd22554) >>> 16) - ((dcr * 64'sd46802) >>> 16));
        b = clamp8(yy + ((dcb * 64'sd116130) >>> 16));
    endfunction

    task automatic check_int(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_block(input exp_t e);
        int bad = -1;
        n_checks++;
        for (int i = 0; i < NPIX; i++)
            if (bad < 0 && (r_all[i*8 +: 8] !== e.r[i*8 +: 8] || g_all[i*8 +: 8] !== e.g[i*8 +: 8] ||
                            b_all[i*8 +: 8] !== e.b[i*8 +: 8]))
                bad = i;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s pixel %0d: got RGB=%0d/%0d/%0d, expected %0d/%0d/%0d", e.name, bad,
                     r_all[bad*8 +: 8], g_all[bad*8 +: 8], b_all[bad*8 +: 8],
                     e.r[bad*8 +: 8], e.g[bad*8 +: 8], e.b[bad*8 +: 8]);
        end
    endtask

    function automatic bit near(input logic [7:0] a, input logic [7:0] b);
        return (int'(a) - int'(b) <= 1) && (int'(b) - int'(a) <= 1);
    endfunction

    task automatic cmp_tol(input string nm, input logic [511:0] orr, input logic [511:0] og,
                           input logic [511:0] ob);
        int bad = -1;
        n_checks++;
        for (int i = 0; i < NPIX; i++)
            if (bad < 0 && !(near(r_all[i*8 +: 8], orr[i*8 +: 8]) && near(g_all[i*8 +: 8], og[i*8 +: 8]) &&
                             near(b_all[i*8 +: 8], ob[i*8 +: 8])))
                bad = i;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s round-trip pixel %0d: got RGB=%0d/%0d/%0d, original %0d/%0d/%0d", nm, bad,
                     r_all[bad*8 +: 8], g_all[bad*8 +: 8], b_all[bad*8 +: 8],
                     orr[bad*8 +: 8], og[bad*8 +: 8], ob[bad*8 +: 8]);
        end
    endtask

    task automatic push_model(input string nm);
        exp_t e;
        logic [7:0] r, g, b;
        e.name = nm;
        for (int i = 0; i < NPIX; i++) begin
            model(y_all[i*32 +: 32], cb_all[i*32 +: 32], cr_all[i*32 +: 32], r, g, b);
            e.r[i*8 +: 8] = r;
            e.g[i*8 +: 8] = g;
            e.b[i*8 +: 8] = b;
        end
        sb.push_back(e);
    endtask

    // Issues start, measures start-edge to done latency, scores, then walks the done handshake.
    task automatic run_block(input string nm, input bit hold, input bit change_mid);
        int   cnt;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        if (change_mid) begin
            y_all  = ~y_all;
            cb_all = '0;
            cr_all = {NPIX{32'h00FF0000}};
        end
        cnt = 0;
        while (!done && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check_int({nm, " latency"}, cnt, 8);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty at done, got 0 entries, expected 1", nm);
        end else begin
            e = sb.pop_front();
            cmp_block(e);
        end
        if (hold) begin
            @(negedge clk);
            check_int({nm, " done held"}, done, 1);
            start = 1'b0;
        end
        @(negedge clk);
        check_int({nm, " done drop"}, done, 0);
    endtask

    initial begin
        exp_t e;
        logic [511:0] orr, og, ob;

        vecs[0] = '{"mid grey",     32'h00800000, 32'h00800000, 32'h00800000, 8'd128, 8'd128, 8'd128, 1'b0};
        vecs[1] = '{"all 255",      32'h00FF0000, 32'h00FF0000, 32'h00FF0000, 8'd255, 8'd121, 8'd255, 1'b1};
        vecs[2] = '{"all zero",     32'h00000000, 32'h00000000, 32'h00000000, 8'd0,   8'd135, 8'd0,   1'b0};
        vecs[3] = '{"mixed A",      32'h00500000, 32'h00400000, 32'h00C00000, 8'd170, 8'd56,  8'd0,   1'b1};
        vecs[4] = '{"mixed B",      32'h00C08000, 32'h00A00000, 32'h00600000, 8'd148, 8'd204, 8'd249, 1'b0};
        vecs[5] = '{"negative Y",   32'hFFF00000, 32'h00800000, 32'h00800000, 8'd0,   8'd0,   8'd0,   1'b0};

        rst = 1'b1;
        start = 1'b0;
        y_all = '0; cb_all = '0; cr_all = '0;
        repeat (3) @(negedge clk);
        check_int("reset done", done, 0);
        check_int("reset r_all zero", longint'(r_all != '0), 0);
        check_int("reset g_all zero", longint'(g_all != '0), 0);
        check_int("reset b_all zero", longint'(b_all != '0), 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            y_all  = {NPIX{vecs[v].y}};
            cb_all = {NPIX{vecs[v].cb}};
            cr_all = {NPIX{vecs[v].cr}};
            e.name = vecs[v].name;
            e.r = {NPIX{vecs[v].r}};
            e.g = {NPIX{vecs[v].g}};
            e.b = {NPIX{vecs[v].b}};
            sb.push_back(e);
            run_block(vecs[v].name, vecs[v].hold, 1'b0);
        end

        // Round trip: forward-convert random RGB with real arithmetic, expect recovery within 1 LSB.
        for (int blk = 0; blk < 20; blk++) begin
            for (int i = 0; i < NPIX; i++) begin
                real rr, gg, bb;
                orr[i*8 +: 8] = 8'($urandom_range(0, 255));
                og[i*8 +: 8]  = 8'($urandom_range(0, 255));
                ob[i*8 +: 8]  = 8'($urandom_range(0, 255));
                rr = real'(orr[i*8 +: 8]); gg = real'(og[i*8 +: 8]); bb = real'(ob[i*8 +: 8]);
                y_all[i*32 +: 32]  = 32'($rtoi((0.299*rr + 0.587*gg + 0.114*bb) * 65536.0 + 0.5));
                cb_all[i*32 +: 32] = 32'($rtoi((-0.168736*rr - 0.331264*gg + 0.5*bb + 128.0) * 65536.0 + 0.5));
                cr_all[i*32 +: 32] = 32'($rtoi((0.5*rr - 0.418688*gg - 0.081312*bb + 128.0) * 65536.0 + 0.5));
            end
            push_model($sformatf("random block %0d", blk));
            run_block($sformatf("random block %0d", blk), 1'b1, 1'b0);
            cmp_tol($sformatf("random block %0d", blk), orr, og, ob);
        end

        // Inputs disturbed and start held during BUSY: result must be the latched block only.
        y_all  = {NPIX{32'h00500000}};
        cb_all = {NPIX{32'h00400000}};
        cr_all = {NPIX{32'h00C00000}};
        e.name = "latched inputs";
        e.r = {NPIX{8'd170}};
        e.g = {NPIX{8'd56}};
        e.b = {NPIX{8'd0}};
        sb.push_back(e);
        run_block("latched inputs", 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check_int("no second conversion", done, 0);
        cmp_block(e);

        // Asynchronous reset after batch 3 of BUSY.
        y_all  = {NPIX{32'h00800000}};
        cb_all = {NPIX{32'h00800000}};
        cr_all = {NPIX{32'h00800000}};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_int("async reset done", done, 0);
        check_int("async reset r_all zero", longint'(r_all != '0), 0);
        check_int("async reset g_all zero", longint'(g_all != '0), 0);
        check_int("async reset b_all zero", longint'(b_all != '0), 0);
        @(negedge clk);
        rst = 1'b0;
        push_model("after reset");
        run_block("after reset", 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
